// File: rtl/ssio_sdr_in_deser_pkg.sv
// ssio_sdr_in_deser_pkg
//   Shared definitions for the SDR input deserialiser. It provides the
//   assembler state encoding, a constant clog2 helper and the legal parameter
//   ranges that the top level checks at elaboration.
package ssio_sdr_in_deser_pkg;

    typedef enum logic {
        ASM_IDLE  = 1'b0,
        ASM_ACCUM = 1'b1
    } asm_state_e;

    localparam int unsigned WIDTH_MIN    = 1;
    localparam int unsigned WIDTH_MAX    = 16;
    localparam int unsigned RATIO_MIN    = 1;
    localparam int unsigned RATIO_MAX    = 8;
    localparam int unsigned PIPELINE_MAX = 4;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    // Beat index needs at least one bit even when RATIO is 1.
    function automatic int unsigned idx_width(input int unsigned ratio);
        return (clog2(ratio) < 1) ? 1 : clog2(ratio);
    endfunction

    function automatic bit params_ok(input int unsigned w, input int unsigned r,
                                     input int unsigned p);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX) &&
               (r >= RATIO_MIN) && (r <= RATIO_MAX) &&
               (p <= PIPELINE_MAX);
    endfunction

endpackage

// File: rtl/ssio_sdr_pipe.sv
// ssio_sdr_pipe
//   Retiming shift register of depth DEPTH for one beat of {data, valid, err}.
//   Only the valid/err bits are reset; data bits run free.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_d/in_valid/in_err  beat entering the chain
//   head_*                oldest stage of the chain
//   peek_valid            valid bit of the stage feeding the head (lookahead)
module ssio_sdr_pipe #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_d,
    input  logic             in_valid,
    input  logic             in_err,
    output logic [WIDTH-1:0] head_d,
    output logic             head_valid,
    output logic             head_err,
    output logic             peek_valid
);

    logic [WIDTH-1:0] d_q [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] e_q;

    always_ff @(posedge clk) begin
        d_q[0] <= in_d;
        for (int unsigned i = 1; i < DEPTH; i++) d_q[i] <= d_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            e_q <= '0;
        end else begin
            v_q[0] <= in_valid;
            e_q[0] <= in_err;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                v_q[i] <= v_q[i-1];
                e_q[i] <= e_q[i-1];
            end
        end
    end

    assign head_d     = d_q[DEPTH-1];
    assign head_valid = v_q[DEPTH-1];
    assign head_err   = e_q[DEPTH-1];

    // With a single stage the lookahead is the chain input itself.
    if (DEPTH == 1) begin : g_peek_in
        assign peek_valid = in_valid;
    end else begin : g_peek_stage
        assign peek_valid = v_q[DEPTH-2];
    end

endmodule

// File: rtl/ssio_sdr_in_deser.sv
// ssio_sdr_in_deser
//   Source-synchronous SDR input capture: I/O register, PIPELINE retiming
//   stages, then packs RATIO valid beats (LSB first) into one word with keep,
//   last and error framing. No backpressure.
// Ports:
//   clk          receive clock (rising edge)
//   rst          synchronous active-high reset
//   input_d      beat data from pins
//   input_valid  beat qualifier (rx_dv)
//   input_err    beat error (rx_er)
//   output_q     assembled word, beat 0 in the low lane
//   output_keep  lane-present mask
//   output_valid one-cycle word strobe
//   output_last  word ends the frame
//   output_err   OR of beat errors in the word
module ssio_sdr_in_deser
    import ssio_sdr_in_deser_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned RATIO    = 2,
    parameter int unsigned PIPELINE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       input_d,
    input  logic                   input_valid,
    input  logic                   input_err,
    output logic [WIDTH*RATIO-1:0] output_q,
    output logic [RATIO-1:0]       output_keep,
    output logic                   output_valid,
    output logic                   output_last,
    output logic                   output_err
);

    localparam int unsigned IDXW = idx_width(RATIO);
    localparam int unsigned QW   = WIDTH * RATIO;

    if (!params_ok(WIDTH, RATIO, PIPELINE)) begin : g_param_check
        $error("ssio_sdr_in_deser: WIDTH/RATIO/PIPELINE out of range");
    end

    // Capture register, intended to be packed into the input pad cell.
    (* IOB = "TRUE" *) logic [WIDTH-1:0] s0_d;
    (* IOB = "TRUE" *) logic             s0_valid;
    (* IOB = "TRUE" *) logic             s0_err;

    always_ff @(posedge clk) begin
        s0_d <= input_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_err   <= 1'b0;
        end else begin
            s0_valid <= input_valid;
            s0_err   <= input_err;
        end
    end

    logic [WIDTH-1:0] head_d;
    logic             head_valid;
    logic             head_err;
    logic             peek_valid;

    ssio_sdr_pipe #(
        .WIDTH (WIDTH),
        .DEPTH (PIPELINE + 1)
    ) u_pipe (
        .clk        (clk),
        .rst        (rst),
        .in_d       (s0_d),
        .in_valid   (s0_valid),
        .in_err     (s0_err),
        .head_d     (head_d),
        .head_valid (head_valid),
        .head_err   (head_err),
        .peek_valid (peek_valid)
    );

    asm_state_e       state_q, state_n;
    logic [IDXW-1:0]  idx_q, idx_n, lane;
    logic [QW-1:0]    buf_q, buf_n, q_n;
    logic [RATIO-1:0] keep_q, keep_n, okeep_n;
    logic             err_q, err_n, oerr_n, olast_n, ovalid_n;
    logic             word_done;

    always_comb begin
        state_n   = state_q;
        idx_n     = idx_q;
        buf_n     = buf_q;
        keep_n    = keep_q;
        err_n     = err_q;
        q_n       = output_q;
        okeep_n   = output_keep;
        oerr_n    = output_err;
        olast_n   = output_last;
        ovalid_n  = 1'b0;
        word_done = 1'b0;
        lane      = (state_q == ASM_IDLE) ? '0 : idx_q;

        if (state_q == ASM_IDLE) begin
            buf_n  = '0;
            keep_n = '0;
            err_n  = 1'b0;
        end

        if (head_valid) begin
            buf_n[32'(lane)*WIDTH +: WIDTH] = head_d;
            keep_n[lane] = 1'b1;
            err_n        = err_n | head_err;
            // Close on the top lane, or when the lookahead shows the frame ends here.
            word_done    = (lane == IDXW'(RATIO - 1)) || !peek_valid;
            if (word_done) begin
                ovalid_n = 1'b1;
                q_n      = buf_n;
                okeep_n  = keep_n;
                oerr_n   = err_n;
                olast_n  = !peek_valid;
                buf_n    = '0;
                keep_n   = '0;
                err_n    = 1'b0;
                idx_n    = '0;
                state_n  = peek_valid ? ASM_ACCUM : ASM_IDLE;
            end else begin
                idx_n   = lane + IDXW'(1);
                state_n = ASM_ACCUM;
            end
        end else begin
            state_n = ASM_IDLE;
            idx_n   = '0;
            buf_n   = '0;
            keep_n  = '0;
            err_n   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ASM_IDLE;
            idx_q        <= '0;
            buf_q        <= '0;
            keep_q       <= '0;
            err_q        <= 1'b0;
            output_q     <= '0;
            output_keep  <= '0;
            output_valid <= 1'b0;
            output_last  <= 1'b0;
            output_err   <= 1'b0;
        end else begin
            state_q      <= state_n;
            idx_q        <= idx_n;
            buf_q        <= buf_n;
            keep_q       <= keep_n;
            err_q        <= err_n;
            output_q     <= q_n;
            output_keep  <= okeep_n;
            output_valid <= ovalid_n;
            output_last  <= olast_n;
            output_err   <= oerr_n;
        end
    end

endmodule

// File: tb/tb_ssio_sdr_in_deser.sv
module tb_ssio_sdr_in_deser;

    typedef struct {
        int          c;
        logic [63:0] q;
        logic [7:0]  keep;
        logic        last;
        logic        err;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst    = 1'b1;
    logic [7:0] din    = '0;
    logic       dvalid = 1'b0;
    logic       derr   = 1'b0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_chk  = 0;
    int n_fail = 0;

    // Main instance: WIDTH=4 RATIO=2 PIPELINE=1
    logic [7:0] m_q;
    logic [1:0] m_keep;
    logic       m_valid, m_last, m_err;
    ssio_sdr_in_deser #(.WIDTH(4), .RATIO(2), .PIPELINE(1)) u_dut (
        .clk(clk), .rst(rst), .input_d(din[3:0]), .input_valid(dvalid), .input_err(derr),
        .output_q(m_q), .output_keep(m_keep), .output_valid(m_valid),
        .output_last(m_last), .output_err(m_err)
    );

    // Sweep A: WIDTH=8 RATIO=4 PIPELINE=4
    logic [31:0] a_q;
    logic [3:0]  a_keep;
    logic        a_valid, a_last, a_err;
    ssio_sdr_in_deser #(.WIDTH(8), .RATIO(4), .PIPELINE(4)) u_a (
        .clk(clk), .rst(rst), .input_d(din), .input_valid(dvalid), .input_err(derr),
        .output_q(a_q), .output_keep(a_keep), .output_valid(a_valid),
        .output_last(a_last), .output_err(a_err)
    );

    // Sweep B: WIDTH=1 RATIO=8 PIPELINE=0
    logic [7:0] b_q;
    logic [7:0] b_keep;
    logic       b_valid, b_last, b_err;
    ssio_sdr_in_deser #(.WIDTH(1), .RATIO(8), .PIPELINE(0)) u_b (
        .clk(clk), .rst(rst), .input_d(din[0:0]), .input_valid(dvalid), .input_err(derr),
        .output_q(b_q), .output_keep(b_keep), .output_valid(b_valid),
        .output_last(b_last), .output_err(b_err)
    );

    // Sweep C: WIDTH=8 RATIO=1 PIPELINE=0
    logic [7:0] c_q;
    logic [0:0] c_keep;
    logic       c_valid, c_last, c_err;
    ssio_sdr_in_deser #(.WIDTH(8), .RATIO(1), .PIPELINE(0)) u_c (
        .clk(clk), .rst(rst), .input_d(din), .input_valid(dvalid), .input_err(derr),
        .output_q(c_q), .output_keep(c_keep), .output_valid(c_valid),
        .output_last(c_last), .output_err(c_err)
    );

    function automatic rec_t mk(input int c, input logic [63:0] q, input logic [7:0] k,
                                input logic l, input logic e);
        rec_t r;
        r.c = c; r.q = q; r.keep = k; r.last = l; r.err = e;
        return r;
    endfunction

    rec_t qm[$], qa[$], qb[$], qc[$];

    always @(negedge clk) begin
        if (m_valid === 1'b1) qm.push_back(mk(cyc, 64'(m_q), 8'(m_keep), m_last, m_err));
        if (a_valid === 1'b1) qa.push_back(mk(cyc, 64'(a_q), 8'(a_keep), a_last, a_err));
        if (b_valid === 1'b1) qb.push_back(mk(cyc, 64'(b_q), 8'(b_keep), b_last, b_err));
        if (c_valid === 1'b1) qc.push_back(mk(cyc, 64'(c_q), 8'(c_keep), c_last, c_err));
    end

    logic [7:0] fd   [32];
    logic       fe   [32];
    int         fcap [32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rec(input string tag, input rec_t r, input int c, input logic [63:0] q,
                           input logic [7:0] k, input logic l, input logic e);
        chk({tag, "_cycle"}, 64'(r.c), 64'(c));
        chk({tag, "_q"},     r.q, q);
        chk({tag, "_keep"},  64'(r.keep), 64'(k));
        chk({tag, "_last"},  64'(r.last), 64'(l));
        chk({tag, "_err"},   64'(r.err), 64'(e));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 64'(m_valid), 64'd0);
        chk({tag, "_q"},     64'(m_q), 64'd0);
        chk({tag, "_keep"},  64'(m_keep), 64'd0);
        chk({tag, "_last"},  64'(m_last), 64'd0);
        chk({tag, "_err"},   64'(m_err), 64'd0);
    endtask

    task automatic beat(input logic [7:0] d, input logic v, input logic e, output int cap);
        @(negedge clk);
        din = d; dvalid = v; derr = e;
        cap = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din = '0; dvalid = 1'b0; derr = 1'b0;
        end
    endtask

    // Reference: a frame of L beats splits into ceil(L/R) words of consecutive beats.
    task automatic check_frame(input int which, input int L);
        rec_t        g[$];
        string       nm;
        int          W, R, P, nw, nl, lastb, k;
        logic [63:0] exq;
        logic [7:0]  exk;
        logic        exe;
        case (which)
            0:       begin g = qa; nm = "A_w8r4p4"; W = 8; R = 4; P = 4; end
            1:       begin g = qb; nm = "B_w1r8p0"; W = 1; R = 8; P = 0; end
            default: begin g = qc; nm = "C_w8r1p0"; W = 8; R = 1; P = 0; end
        endcase
        nw = (L + R - 1) / R;
        chk($sformatf("%s_L%0d_words", nm, L), 64'(g.size()), 64'(nw));
        nl = 0;
        for (int w = 0; w < nw; w++) begin
            if (w < g.size()) begin
                exq = '0; exk = '0; exe = 1'b0; lastb = 0;
                for (int b = 0; b < R; b++) begin
                    k = w * R + b;
                    if (k < L) begin
                        exq = exq | ((64'(fd[k]) & ((64'd1 << W) - 64'd1)) << (b * W));
                        exk[b] = 1'b1;
                        exe = exe | fe[k];
                        lastb = k;
                    end
                end
                chk_rec($sformatf("%s_L%0d_w%0d", nm, L, w), g[w], fcap[lastb] + P + 2,
                        exq, exk, (w == nw - 1), exe);
                nl += int'(g[w].last);
            end
        end
        chk($sformatf("%s_L%0d_lastcount", nm, L), 64'(nl), 64'd1);
    endtask

    initial begin
        int c0, c1, c2, c3, c4, tmp, L;

        // 1: reset and idle
        idle(3);
        chk_zero("reset");
        rst = 1'b0;
        idle(6);
        chk("idle_no_strobe", 64'(qm.size()), 64'd0);

        // 2: full byte stream
        qm.delete();
        beat(8'h5, 1, 0, c0);
        beat(8'hD, 1, 0, c1);
        beat(8'h3, 1, 0, c2);
        beat(8'hA, 1, 0, c3);
        idle(8);
        chk("t2_count", 64'(qm.size()), 64'd2);
        if (qm.size() > 0) chk_rec("t2_w0", qm[0], c1 + 3, 64'hD5, 8'h3, 1'b0, 1'b0);
        if (qm.size() > 1) chk_rec("t2_w1", qm[1], c3 + 3, 64'hA3, 8'h3, 1'b1, 1'b0);
        chk("t2_hold_valid", 64'(m_valid), 64'd0);
        chk("t2_hold_q", 64'(m_q), 64'hA3);

        // 3: odd beat count
        qm.delete();
        beat(8'h1, 1, 0, c0);
        beat(8'h2, 1, 0, c1);
        beat(8'h3, 1, 0, c2);
        idle(8);
        chk("t3_count", 64'(qm.size()), 64'd2);
        if (qm.size() > 0) chk_rec("t3_w0", qm[0], c1 + 3, 64'h21, 8'h3, 1'b0, 1'b0);
        if (qm.size() > 1) chk_rec("t3_w1", qm[1], c2 + 3, 64'h03, 8'h1, 1'b1, 1'b0);

        // 4: error, one-beat gap, realignment
        qm.delete();
        beat(8'h7, 1, 1, c0);
        beat(8'h8, 1, 0, c1);
        beat(8'h0, 0, 1, tmp);
        beat(8'h9, 1, 0, c3);
        beat(8'h4, 1, 0, c4);
        idle(8);
        chk("t4_count", 64'(qm.size()), 64'd2);
        if (qm.size() > 0) chk_rec("t4_a", qm[0], c1 + 3, 64'h87, 8'h3, 1'b1, 1'b1);
        if (qm.size() > 1) chk_rec("t4_b", qm[1], c4 + 3, 64'h49, 8'h3, 1'b1, 1'b0);

        // 5: reset while 0x6 sits in the assembler
        qm.delete();
        beat(8'h6, 1, 0, c0);
        beat(8'h7, 1, 0, c1);
        beat(8'h0, 0, 0, tmp);
        beat(8'h0, 0, 0, tmp);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("t5_rst");
        rst = 1'b0;
        beat(8'hE, 1, 0, c2);
        beat(8'hF, 1, 0, c3);
        idle(10);
        chk("t5_count", 64'(qm.size()), 64'd1);
        if (qm.size() > 0) chk_rec("t5_w0", qm[0], c3 + 3, 64'hFE, 8'h3, 1'b1, 1'b0);

        // 6: parameter sweep
        idle(12);
        qa.delete(); qb.delete(); qc.delete();
        for (int f = 0; f < 4; f++) begin
            case (f)
                0:       L = 1;
                1:       L = 8;
                2:       L = 9;
                default: L = int'($urandom_range(2, 20));
            endcase
            for (int k = 0; k < L; k++) begin
                fd[k] = 8'($urandom_range(0, 255));
                fe[k] = ($urandom_range(0, 5) == 0);
                beat(fd[k], 1'b1, fe[k], fcap[k]);
            end
            idle(12);
            for (int which = 0; which < 3; which++) check_frame(which, L);
            qa.delete(); qb.delete(); qc.delete();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
